// File: rtl/frame_buffer_dp.sv
// ---------------------------------------------------------------------------
// frame_buffer_dp
//   Single-clock, dual-port pixel frame buffer with a hardware clear engine
//   and optional double buffering with a frame-synchronous page swap.
//
//   Port A (CPU bus): word read/write on the back page. Reads are registered
//     and read-first. Writes are ignored while the clear engine runs.
//   Port B (VGA):     pixel read on the front page. Registered, never stalled.
//   Clear engine:     CLR_START fills the back page with CLR_VALUE, one word
//     per cycle. A_BUSY is high while it runs and CLR_DONE pulses once at
//     the end.
//   Swap:             SWAP_REQ arms SWAP_PENDING. The next FRAME_START seen
//     while idle toggles FRONT_SEL.
//
//   Optional build macro FRAME_BUFFER_DOUBLE_BUF_EN:
//     defined   -> two pages; FRONT_SEL selects the page displayed on port B.
//     undefined -> one page shared by both ports and the clear engine.
//                  FRONT_SEL and SWAP_PENDING read 0, and SWAP_REQ and
//                  FRAME_START are ignored.
//
//   Ports: CLK, RESET (async, active low), A_ADDR/A_DATA_IN/A_WE/A_DATA_OUT/
//   A_BUSY, CLR_START/CLR_VALUE/CLR_DONE, SWAP_REQ/FRAME_START/SWAP_PENDING/
//   FRONT_SEL, B_ADDR/B_DATA_OUT.
// ---------------------------------------------------------------------------
module frame_buffer_dp #(
  parameter int ADDR_X_W = 8,
  parameter int ADDR_Y_W = 7,
  parameter int BPP      = 1,
  parameter int WORD_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [ADDR_Y_W+ADDR_X_W-1:0] A_ADDR,
  input  logic [WORD_W-1:0]            A_DATA_IN,
  input  logic                         A_WE,
  output logic [WORD_W-1:0]            A_DATA_OUT,
  output logic                         A_BUSY,
  input  logic                         CLR_START,
  input  logic [WORD_W-1:0]            CLR_VALUE,
  output logic                         CLR_DONE,
  input  logic                         SWAP_REQ,
  input  logic                         FRAME_START,
  output logic                         SWAP_PENDING,
  output logic                         FRONT_SEL,
  input  logic [ADDR_Y_W+ADDR_X_W-1:0] B_ADDR,
  output logic [BPP-1:0]               B_DATA_OUT
);
  localparam int PIX_PER_WORD = WORD_W / BPP;
  localparam int AW     = ADDR_Y_W + ADDR_X_W;
  localparam int SUB_W  = $clog2(PIX_PER_WORD);
  localparam int SUB_WX = (SUB_W > 0) ? SUB_W : 1;
  localparam int IDX_W  = AW - SUB_W;
  localparam int DEPTH  = (2**AW) / PIX_PER_WORD;
`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
  localparam int MEM_AW = IDX_W + 1;
`else
  localparam int MEM_AW = IDX_W;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [IDX_W-1:0]    clr_cnt;
  logic [WORD_W-1:0]   clr_fill;
  logic [WORD_W-1:0]   mem [0:(2**MEM_AW)-1];

  logic [IDX_W-1:0]    a_idx, b_idx;
  logic [SUB_WX-1:0]   b_sub;
  logic [MEM_AW-1:0]   a_mem_addr, b_mem_addr, clr_mem_addr;

  assign a_idx = A_ADDR[AW-1:SUB_W];
  assign b_idx = B_ADDR[AW-1:SUB_W];

  // Port A works on whole words, so its pixel-select bits are dropped.
  generate
    if (SUB_W > 0) begin : g_sub
      assign b_sub = B_ADDR[SUB_W-1:0];
      logic unused_a_sub;
      assign unused_a_sub = &{1'b0, A_ADDR[SUB_W-1:0]};
    end else begin : g_nosub
      assign b_sub = '0;
    end
  endgenerate

`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
  // Top address bit is the page: A and the clear engine use the back page.
  assign a_mem_addr   = {~FRONT_SEL, a_idx};
  assign clr_mem_addr = {~FRONT_SEL, clr_cnt};
  assign b_mem_addr   = { FRONT_SEL, b_idx};

  // Swap only while idle, so the page being cleared never becomes visible.
  // A request coincident with FRAME_START only arms the swap for the next one.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FRONT_SEL    <= 1'b0;
      SWAP_PENDING <= 1'b0;
    end else if (FRAME_START && SWAP_PENDING && state == IDLE) begin
      FRONT_SEL    <= ~FRONT_SEL;
      SWAP_PENDING <= 1'b0;
    end else if (SWAP_REQ) begin
      SWAP_PENDING <= 1'b1;
    end
  end
`else
  assign a_mem_addr   = a_idx;
  assign clr_mem_addr = clr_cnt;
  assign b_mem_addr   = b_idx;
  assign FRONT_SEL    = 1'b0;
  assign SWAP_PENDING = 1'b0;

  logic unused_swap;
  assign unused_swap = &{1'b0, SWAP_REQ, FRAME_START};
`endif

  // Storage has no reset. The clear engine owns the write port while active.
  always_ff @(posedge CLK) begin
    if (state == CLEAR)
      mem[clr_mem_addr] <= clr_fill;
    else if (A_WE)
      mem[a_mem_addr] <= A_DATA_IN;
  end

  // Control FSM plus the registered read ports. A read here sees the
  // pre-write contents, which gives read-first behaviour on port A.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_fill   <= '0;
      A_DATA_OUT <= '0;
      A_BUSY     <= 1'b0;
      CLR_DONE   <= 1'b0;
      B_DATA_OUT <= '0;
    end else begin
      B_DATA_OUT <= mem[b_mem_addr][b_sub*BPP +: BPP];
      CLR_DONE   <= 1'b0;
      case (state)
        IDLE: begin
          A_DATA_OUT <= mem[a_mem_addr];
          if (CLR_START) begin
            clr_fill <= CLR_VALUE;
            clr_cnt  <= '0;
            A_BUSY   <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          // A_DATA_OUT holds its value; A_WE and CLR_START are ignored.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            A_BUSY   <= 1'b0;
            CLR_DONE <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buffer_dp.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_dp
//   Directed and random stimulus for frame_buffer_dp at default parameters,
//   checked against a page-level reference model. The model keeps whole pages
//   as word arrays and treats a clear as one atomic fill when it completes.
//   It tracks whether each page holds defined data, and data checks are
//   skipped on pages with undefined contents.
// ---------------------------------------------------------------------------
module tb_frame_buffer_dp;
  localparam int AW    = 15;
  localparam int DEPTH = 4096;
`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          CLK, RESET;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [7:0]    A_DATA_IN, A_DATA_OUT, CLR_VALUE;
  logic          A_WE, A_BUSY, CLR_START, CLR_DONE;
  logic          SWAP_REQ, FRAME_START, SWAP_PENDING, FRONT_SEL;
  logic [0:0]    B_DATA_OUT;

  frame_buffer_dp dut (
    .CLK(CLK), .RESET(RESET),
    .A_ADDR(A_ADDR), .A_DATA_IN(A_DATA_IN), .A_WE(A_WE),
    .A_DATA_OUT(A_DATA_OUT), .A_BUSY(A_BUSY),
    .CLR_START(CLR_START), .CLR_VALUE(CLR_VALUE), .CLR_DONE(CLR_DONE),
    .SWAP_REQ(SWAP_REQ), .FRAME_START(FRAME_START),
    .SWAP_PENDING(SWAP_PENDING), .FRONT_SEL(FRONT_SEL),
    .B_ADDR(B_ADDR), .B_DATA_OUT(B_DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [2][DEPTH];
  bit         m_known [2];
  bit         m_front, m_pend;
  int         m_busy_left;          // clear cycles still to run; 0 = idle
  logic [7:0] m_fill, exp_a;
  logic       exp_b, exp_done;
  bit         a_known, b_known;

  function automatic int back_pg();
    return DBL ? int'(!m_front) : 0;
  endfunction

  function automatic int front_pg();
    return DBL ? int'(m_front) : 0;
  endfunction

  // One clock edge of behaviour, using the inputs as presented at that edge.
  function automatic void model_edge();
    int  bp = back_pg();
    int  fp = front_pg();
    bit  idle = (m_busy_left == 0);
    logic [7:0] bw = m_mem[fp][B_ADDR >> 3];
    exp_b   = bw[B_ADDR % 8];
    // A page being filled word by word has no single defined state.
    b_known = m_known[fp] && (idle || fp != bp);
    exp_done = 1'b0;
    if (!idle) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[bp][i] = m_fill;
        m_known[bp] = 1'b1;
        exp_done    = 1'b1;
      end
    end else begin
      exp_a   = m_mem[bp][A_ADDR >> 3];
      a_known = m_known[bp];
      if (A_WE) m_mem[bp][A_ADDR >> 3] = A_DATA_IN;
      if (CLR_START) begin
        m_busy_left = DEPTH;
        m_fill      = CLR_VALUE;
      end
    end
    if (DBL) begin
      if (FRAME_START && m_pend && idle) begin
        m_front = !m_front;
        m_pend  = 1'b0;
      end else if (SWAP_REQ) begin
        m_pend = 1'b1;
      end
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("busy", A_BUSY, m_busy_left > 0);
    chk("done", CLR_DONE, exp_done);
    chk("pending", SWAP_PENDING, m_pend);
    chk("front", FRONT_SEL, m_front);
    if (a_known) chk("a_data", A_DATA_OUT, exp_a);
    if (b_known) chk("b_data", B_DATA_OUT, exp_b);
  endtask

  task automatic idle_inputs();
    A_WE = 0; CLR_START = 0; SWAP_REQ = 0; FRAME_START = 0;
  endtask

  // Run a full clear, poking port A and optionally FRAME_START mid-way.
  task automatic clear_page(input logic [7:0] fill, input bit mid_fs);
    int busy_n = 0, done_n = 0;
    CLR_VALUE = fill; CLR_START = 1;
    step();
    CLR_START = 0;
    while (A_BUSY === 1'b1 && busy_n < DEPTH + 20) begin
      busy_n++;
      A_WE      = 1'($urandom_range(0, 1));
      A_ADDR    = AW'($urandom_range(0, 511));
      A_DATA_IN = 8'($urandom);
      CLR_START = 1'($urandom_range(0, 7) == 0);
      FRAME_START = mid_fs && (busy_n == 2000);
      step();
      done_n += int'(CLR_DONE);
    end
    idle_inputs();
    chk("busy_len", busy_n, DEPTH);
    chk("done_cnt", done_n, 1);
  endtask

  task automatic do_swap();
    SWAP_REQ = 1;    step(); SWAP_REQ = 0;
    FRAME_START = 1; step(); FRAME_START = 0;
  endtask

  task automatic model_reset();
    if (m_busy_left > 0) m_known[back_pg()] = 1'b0;
    m_front = 0; m_pend = 0; m_busy_left = 0;
    exp_a = '0; exp_b = '0; exp_done = 0; a_known = 1; b_known = 1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a"}, A_DATA_OUT, 0);
    chk({tag, "_b"}, B_DATA_OUT, 0);
    chk({tag, "_busy"}, A_BUSY, 0);
    chk({tag, "_done"}, CLR_DONE, 0);
    chk({tag, "_front"}, FRONT_SEL, 0);
    chk({tag, "_pend"}, SWAP_PENDING, 0);
  endtask

  logic [7:0] pat;

  initial begin
    RESET = 0; idle_inputs();
    A_ADDR = '0; B_ADDR = '0; A_DATA_IN = '0; CLR_VALUE = '0;
    model_reset();
    m_known[0] = 0; m_known[1] = 0;
    repeat (2) @(negedge CLK);
    check_zero_outputs("rst");
    RESET = 1;

    // Bring both pages to a defined state.
    clear_page(8'h00, 0);
    do_swap();
    clear_page(8'h00, 0);

    // Write 0xA5 at 0x0508 and read it back one cycle later.
    A_ADDR = 15'h0508; A_DATA_IN = 8'hA5; A_WE = 1; step();
    A_WE = 0; step();
    chk("rd_0508", A_DATA_OUT, 8'hA5);

    // Show it on port B: pixels 0x0508..0x050F are the bits of 0xA5, LSB first.
    do_swap();
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      B_ADDR = 15'h0508 + AW'(i);
      step();
      chk("b_seq", B_DATA_OUT, pat[i]);
    end

    // Clear to 0xFF with a swap requested and a FRAME_START during the clear.
    SWAP_REQ = 1; step(); SWAP_REQ = 0;
    clear_page(8'hFF, 1);
    A_ADDR = 15'h0000; step();
    chk("rd_0000", A_DATA_OUT, 8'hFF);
    A_ADDR = 15'h7FF8; step();
    chk("rd_7ff8", A_DATA_OUT, 8'hFF);
    FRAME_START = 1; step(); FRAME_START = 0;
    step();

    // Random traffic.
    for (int n = 0; n < 15000; n++) begin
      A_ADDR      = AW'($urandom_range(0, 511));
      B_ADDR      = AW'($urandom_range(0, 511));
      A_DATA_IN   = 8'($urandom);
      A_WE        = 1'($urandom_range(0, 1));
      CLR_VALUE   = 8'($urandom);
      CLR_START   = 1'($urandom_range(0, 2999) == 0);
      SWAP_REQ    = 1'($urandom_range(0, 19) == 0);
      FRAME_START = 1'($urandom_range(0, 29) == 0);
      step();
    end
    idle_inputs();
    while (m_busy_left > 0) step();

    // Reset in the middle of a clear, then recover with full clears.
    CLR_VALUE = 8'h5A; CLR_START = 1; step(); CLR_START = 0;
    repeat (1000) step();
    RESET = 0;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    @(negedge CLK);
    RESET = 1;
    clear_page(8'h3C, 0);
    do_swap();
    clear_page(8'hC3, 0);

    for (int n = 0; n < 2000; n++) begin
      A_ADDR      = AW'($urandom_range(0, 511));
      B_ADDR      = AW'($urandom_range(0, 511));
      A_DATA_IN   = 8'($urandom);
      A_WE        = 1'($urandom_range(0, 1));
      SWAP_REQ    = 1'($urandom_range(0, 9) == 0);
      FRAME_START = 1'($urandom_range(0, 9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/frame_buffer_dp.md
Name: frame_buffer_dp

Overview:
- Parametrised single-clock frame buffer; successor to the fixed 160x120, 1 bpp buffer.
- Generalised pixel depth (BPP), coordinate widths and CPU word width.
- Adds a hardware clear engine and optional double buffering with frame-synchronous page swap.
- Port A serves the microprocessor bus (word read/write); port B serves the VGA signal generator (pixel read).

Parameters:
- ADDR_X_W, 8, X coordinate bits.
- ADDR_Y_W, 7, Y coordinate bits.
- BPP, 1, bits per pixel; power of 2, at most WORD_W.
- WORD_W, 8, port A data width; power of 2, multiple of BPP.
- PIX_PER_WORD, WORD_W/BPP, derived, not overridden.
- DEPTH, 2**(ADDR_X_W+ADDR_Y_W)/PIX_PER_WORD, words per page, derived.

Ports:
- CLK  in  1  single clock for both ports and all logic.
- RESET  in  1  asynchronous, active-low reset.
- A_ADDR  in  ADDR_Y_W+ADDR_X_W  pixel address {Y,X} of the first pixel in the word.
- A_DATA_IN  in  WORD_W  write data; bits [BPP-1:0] hold the lowest-addressed pixel.
- A_WE  in  1  write enable.
- A_DATA_OUT  out  WORD_W  registered read data.
- A_BUSY  out  1  clear engine active.
- CLR_START  in  1  pulse; starts a clear of the back page.
- CLR_VALUE  in  WORD_W  fill word, sampled on CLR_START.
- CLR_DONE  out  1  one-cycle pulse at the end of a clear.
- SWAP_REQ  in  1  pulse; requests a page swap.
- FRAME_START  in  1  one-cycle vsync strobe from the VGA generator.
- SWAP_PENDING  out  1  a swap is requested but not yet applied.
- FRONT_SEL  out  1  page currently displayed.
- B_ADDR  in  ADDR_Y_W+ADDR_X_W  pixel address {Y,X}.
- B_DATA_OUT  out  BPP  registered pixel value.

Behaviour:
- Reset: every output register is driven to 0, state returns to IDLE, pending swap is cleared. Memory contents are not reset.
- Addressing:
  - Word index = A_ADDR >> log2(PIX_PER_WORD).
  - Port A ignores the low log2(PIX_PER_WORD) address bits.
  - Port B selects the pixel with those low bits: slice [sub*BPP +: BPP].
- Pages:
  - Port A reads and writes the back page (~FRONT_SEL).
  - Port B reads the front page (FRONT_SEL).
- Latency:
  - A_DATA_OUT is valid 1 cycle after A_ADDR.
  - On a write, A_DATA_OUT returns the old word (read-first).
  - B_DATA_OUT is valid 1 cycle after B_ADDR.
  - Port B is never stalled.
- FSM state IDLE:
  - Port A writes proceed normally.
  - CLR_START latches CLR_VALUE, resets the word counter to 0 and moves to CLEAR.
- FSM state CLEAR:
  - Writes the fill word to counter index of the back page, one word per cycle.
  - A_BUSY=1. A_WE is ignored. A_DATA_OUT holds its last value.
  - CLR_START is ignored.
  - After writing index DEPTH-1, moves to IDLE; CLR_DONE=1 for that one following cycle.
  - The counter is ADDR_Y_W+ADDR_X_W-log2(PIX_PER_WORD) bits wide and does not wrap during a clear.
- Swap:
  - SWAP_REQ sets SWAP_PENDING.
  - On a FRAME_START while pending and in IDLE: FRONT_SEL toggles and SWAP_PENDING clears on the same edge.
  - FRAME_START during CLEAR: the swap is deferred to the first FRAME_START after the clear completes.
  - SWAP_REQ coinciding with FRAME_START: the swap is applied at the next FRAME_START, not the coincident one.
  - Repeated SWAP_REQ while pending has no additional effect.
- Simultaneous A_WE and CLR_START in IDLE: the A write completes this cycle; the clear starts the next cycle.
- Reset asserted mid-clear aborts the clear; memory is left partially filled.

Optional Feature:
FRAME_BUFFER_DOUBLE_BUF_EN
- Defined: two pages of DEPTH words each; swap logic as described above.
- Undefined: single page of DEPTH words; ports A and B and the clear engine all use that page.
  - FRONT_SEL and SWAP_PENDING are tied to 0.
  - SWAP_REQ and FRAME_START are ignored.

Test Plan:
- Default parameters, double-buffer macro defined; write A_ADDR=0x0508 with data 0xA5, then read the same address -> A_DATA_OUT=0xA5 one cycle later.
- Same write, then issue SWAP_REQ followed by FRAME_START -> FRONT_SEL=1. Then B_ADDR=0x0508..0x050F -> B_DATA_OUT sequence 1,0,1,0,0,1,0,1.
- CLR_START with CLR_VALUE=0xFF:
  - A_BUSY=1 for exactly 4096 cycles, then CLR_DONE pulses once.
  - A_WE during the clear has no effect.
  - Back-page reads at 0x0000 and 0x7FF8 return 0xFF.
- SWAP_REQ, then FRAME_START issued mid-clear -> FRONT_SEL unchanged and SWAP_PENDING=1. The first FRAME_START after CLR_DONE -> FRONT_SEL toggles and SWAP_PENDING=0.
- BPP=4, WORD_W=8; write A_ADDR=0x0002 with data 0x3C -> B_ADDR=0x0002 returns 0xC and B_ADDR=0x0003 returns 0x3, on the page selected by FRONT_SEL.
- Drop RESET low mid-clear -> all outputs 0 and state IDLE. A new CLR_START after reset release completes a full clear.
